// File: rtl/protobuf_varint_encoder_pkg.sv
// Shared protobuf encoding constants and types used by the varint encoder/decoder stages.
package protobuf_pkg;

  localparam int unsigned VARINT_MAX_BYTES_32 = 5;
  localparam int unsigned VARINT_MAX_BYTES_64 = 10;

  // Protobuf wire types
  localparam logic [2:0] VARINT = 3'd0;
  localparam logic [2:0] I64    = 3'd1;
  localparam logic [2:0] LEN    = 3'd2;
  localparam logic [2:0] I32    = 3'd5;

  typedef enum logic {
    IDLE,
    EMIT
  } enc_state_e;

endpackage

// File: rtl/protobuf_varint_encoder_if.sv
// Value-in / byte-out handshake bundle of the varint encoder.
interface protobuf_varint_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_is64;
  logic        in_zigzag;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;

  modport master (
    output in_valid, in_data, in_is64, in_zigzag, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_is64, in_zigzag, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/protobuf_varint.sv
// Empty module; the encoder top is defined in protobuf_varint_encoder.sv.
module protobuf_varint_encoder_unused_stub;
endmodule

// File: rtl/protobuf_zigzag.sv
// Combinational ZigZag mapping for sint32/sint64: (d << 1) ^ sign-fill.
module protobuf_zigzag #(
  parameter int unsigned Width = 64
) (
  input  logic [Width-1:0] in_data,
  output logic [Width-1:0] out_data
);

  assign out_data = {in_data[Width-2:0], 1'b0} ^ {Width{in_data[Width-1]}};

endmodule

// File: rtl/protobuf_varint_encoder.sv
// Streaming base-128 varint encoder: one value in, one byte per cycle out, with
// optional ZigZag mapping and wrapping value/byte status counters.
module protobuf_varint_encoder
  import protobuf_pkg::*;
#(
  parameter int unsigned COUNT_W = 32
) (
  input  logic                  clock_clk,
  input  logic                  reset_reset,
  protobuf_varint_encoder_if.slave bus,
  output logic [COUNT_W-1:0]    value_count,
  output logic [COUNT_W-1:0]    byte_count
);

  enc_state_e state_q, state_d;
  logic [63:0] sr_q, sr_d;
  logic [COUNT_W-1:0] value_count_q, byte_count_q;

  logic [31:0] zz32;
  logic [63:0] zz64;
  logic [63:0] load_val;
  logic        more;
  logic        fire;
  logic        accept;

  protobuf_zigzag #(.Width(32)) u_zigzag32 (
    .in_data  (bus.in_data[31:0]),
    .out_data (zz32)
  );

  protobuf_zigzag #(.Width(64)) u_zigzag64 (
    .in_data  (bus.in_data),
    .out_data (zz64)
  );

  // 32-bit values are zero-extended so negative int32 stays at 5 bytes.
  always_comb begin
    load_val = 64'd0;
    unique case ({bus.in_is64, bus.in_zigzag})
      2'b00:   load_val = {32'd0, bus.in_data[31:0]};
      2'b01:   load_val = {32'd0, zz32};
      2'b10:   load_val = bus.in_data;
      2'b11:   load_val = zz64;
      default: load_val = 64'd0;
    endcase
  end

  assign more = |sr_q[63:7];

  // Output / handshake decode
  always_comb begin
    bus.out_valid = (state_q == EMIT);
    bus.out_data  = bus.out_valid ? {more, sr_q[6:0]} : 8'd0;
    bus.out_last  = bus.out_valid & ~more;
    fire          = bus.out_valid & bus.out_ready;
    bus.in_ready  = (state_q == IDLE) | (fire & bus.out_last);
    accept        = bus.in_valid & bus.in_ready;
  end

  // Next state: a value accepted on the last byte keeps the FSM in EMIT
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = EMIT;
      EMIT: begin
        if (accept) begin
          state_d = EMIT;
        end else if (fire && !more) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sr_d = sr_q;
    if (fire && more) begin
      sr_d = sr_q >> 7;
    end
    if (accept) begin
      sr_d = load_val;
    end
  end

  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      sr_q          <= 64'd0;
      value_count_q <= '0;
      byte_count_q  <= '0;
    end else begin
      sr_q <= sr_d;
      if (fire) begin
        byte_count_q <= byte_count_q + 1'b1;
        if (!more) begin
          value_count_q <= value_count_q + 1'b1;
        end
      end
    end
  end

  assign value_count = value_count_q;
  assign byte_count  = byte_count_q;

endmodule

// File: tb/tb_protobuf_varint_encoder.sv
// Directed + seeded-random bench for protobuf_varint_encoder using an expected-byte scoreboard.
module tb_protobuf_varint_encoder;

  logic        clk;
  logic        rst;
  logic [31:0] value_count;
  logic [31:0] byte_count;

  protobuf_varint_encoder_if bus ();

  protobuf_varint_encoder #(.COUNT_W(32)) dut (
    .clock_clk   (clk),
    .reset_reset (rst),
    .bus         (bus),
    .value_count (value_count),
    .byte_count  (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int fires = 0;
  int last_fire_cyc = 0;
  int exp_vals = 0;
  int exp_bytes = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic eb(input logic [7:0] b, input bit last);
    q.push_back({last, b});
  endtask

  // Reference: ZigZag via arithmetic shift, then 7-bit little-endian groups.
  task automatic push_model(input logic [63:0] d, input bit is64, input bit zz);
    logic [63:0] u;
    logic [31:0] w;
    bit          m;
    if (!is64) begin
      w = d[31:0];
      if (zz) w = (w << 1) ^ 32'($signed(w) >>> 31);
      u = {32'd0, w};
    end else begin
      u = d;
      if (zz) u = (u << 1) ^ 64'($signed(u) >>> 63);
    end
    do begin
      m = (u >> 7) != 64'd0;
      q.push_back({~m, m, u[6:0]});
      u = u >> 7;
    end while (u != 64'd0);
  endtask

  task automatic step(output bit acc);
    logic [8:0] e;
    #1;
    acc = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      fires++;
      last_fire_cyc = cyc;
      if (q.size() == 0) begin
        chk("unexpected_byte", 64'(q.size()), 64'd1);
      end else begin
        e = q.pop_front();
        chk("byte", {55'd0, bus.out_last, bus.out_data}, {55'd0, e});
        exp_bytes++;
        if (e[8]) exp_vals++;
      end
    end else if (bus.out_valid) begin
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      if (q.size() != 0) chk("stall_hold", {55'd0, bus.out_last, bus.out_data}, {55'd0, q[0]});
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [63:0] d, input bit is64, input bit zz);
    bit acc;
    acc = 1'b0;
    bus.in_data   = d;
    bus.in_is64   = is64;
    bus.in_zigzag = zz;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) step(acc);
    chk("accept", 64'(acc), 64'd1);
    // Scramble side inputs after accept; value in flight must not change
    bus.in_valid  = 1'b0;
    bus.in_is64   = ~is64;
    bus.in_zigzag = ~zz;
    bus.in_data   = ~d;
  endtask

  task automatic drain();
    bit acc;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && (q.size() != 0 || bus.out_valid); i++) step(acc);
    chk("drain_queue", 64'(q.size()), 64'd0);
    chk("drain_out_valid", 64'(bus.out_valid), 64'd0);
    chk("value_count", 64'(value_count), 64'(exp_vals));
    chk("byte_count", 64'(byte_count), 64'(exp_bytes));
  endtask

  task automatic chk_reset_state();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_value_count", 64'(value_count), 64'd0);
    chk("rst_byte_count", 64'(byte_count), 64'd0);
  endtask

  initial begin
    bit          acc;
    int          t0;
    int          f0;
    logic [63:0] d;
    bit          is64;
    bit          zz;
    bit          pat[5];

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 64'd0;
    bus.in_is64   = 1'b0;
    bus.in_zigzag = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state();

    // Back-to-back 10, 127, 128 with no bubble
    t0 = cyc;
    eb(8'h0a, 1); send(64'd10, 0, 0);
    eb(8'h7f, 1); send(64'd127, 0, 0);
    eb(8'h80, 0); eb(8'h01, 1); send(64'd128, 0, 0);
    drain();
    chk("no_bubble", 64'(last_fire_cyc - t0), 64'd4);
    chk("tp1_values", 64'(value_count), 64'd3);
    chk("tp1_bytes", 64'(byte_count), 64'd4);

    eb(8'h8a, 0); eb(8'h9f, 0); eb(8'hd2, 0); eb(8'hf5, 0); eb(8'h0a, 1);
    send(64'hFFFF_FFFF_AEB4_8F8A, 0, 0);
    eb(8'hff, 0); eb(8'hff, 0); eb(8'hff, 0); eb(8'hff, 0); eb(8'h0f, 1);
    send(64'h0000_0000_FFFF_FFFF, 0, 0);
    eb(8'h00, 1);
    send(64'h1234_5678_0000_0000, 0, 0);
    drain();

    eb(8'h8a, 0); eb(8'h9f, 0); eb(8'hd2, 0); eb(8'hf5, 0); eb(8'hea, 0); eb(8'h80, 0);
    eb(8'h02, 1);
    send(64'h0000_0806_AEB4_8F8A, 1, 0);
    for (int i = 0; i < 9; i++) eb(8'hff, 0);
    eb(8'h01, 1);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    drain();

    // ZigZag
    eb(8'h01, 1); send(64'h0000_0000_FFFF_FFFF, 0, 1);
    eb(8'h09, 1); send(64'hFFFF_FFFF_FFFF_FFFB, 1, 1);
    eb(8'h02, 1); send(64'd1, 0, 1);
    for (int i = 0; i < 9; i++) eb(8'hff, 0);
    eb(8'h01, 1);
    send(64'h8000_0000_0000_0000, 1, 1);
    drain();

    // Backpressure: out_ready 1,0,0,1,1 while encoding 128
    eb(8'h80, 0); eb(8'h01, 1);
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.in_data = 64'd128; bus.in_is64 = 1'b0; bus.in_zigzag = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid  = (i == 0);
      bus.out_ready = pat[i];
      step(acc);
      if (i == 0) chk("bp_accept", 64'(acc), 64'd1);
    end
    drain();

    for (int k = 0; k < 8; k++) begin
      d    = {$urandom, $urandom} >> $urandom_range(0, 63);
      is64 = $urandom_range(0, 1) == 1;
      zz   = $urandom_range(0, 1) == 1;
      push_model(d, is64, zz);
      send(d, is64, zz);
    end
    drain();

    // Reset after the second byte of a 10-byte value
    push_model(64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    f0 = fires;
    for (int i = 0; i < 10 && fires < f0 + 2; i++) step(acc);
    chk("rst_mid_progress", 64'(fires - f0), 64'd2);
    rst = 1'b1;
    step(acc);
    rst = 1'b0;
    q.delete();
    exp_vals  = 0;
    exp_bytes = 0;
    chk_reset_state();
    eb(8'h05, 1);
    send(64'd5, 0, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
